// File: rtl/dcmac_0_prbs_pkg.sv
// Shared types and constants for the time-sliced PRBS/counter traffic source.
package dcmac_0_prbs_pkg;

  localparam int BUS_BYTES = 192;
  localparam int PRBS_W    = 16;

  // The window holds b[m-16] in bit 0 through b[m-1] in bit 15.
  // These are the window positions of b[m-16], b[m-14], b[m-13] and b[m-11].
  localparam int TAP_A = 0;
  localparam int TAP_B = 2;
  localparam int TAP_C = 3;
  localparam int TAP_D = 5;

  localparam logic [15:0] INIT_SEED_DEF = 16'hACE1;
  localparam logic [7:0]  MAX_BYTES     = 8'd192;

  typedef logic [PRBS_W-1:0]          ctx_t;
  typedef logic [BUS_BYTES-1:0][7:0]  bus_t;

  // Advance the bit window by one byte (8 new bits). The result is {new byte, previous byte}.
  function automatic ctx_t prbs_byte_step(input ctx_t w);
    ctx_t r;
    r = w;
    for (int i = 0; i < 8; i++) begin
      r = {r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D], r[PRBS_W-1:1]};
    end
    return r;
  endfunction

endpackage

// File: rtl/dcmac_0_prbs_tx_step.sv
// Combinational unroll: from a 16-bit context, produce the next 192 stream bytes (PRBS or counter).
module dcmac_0_prbs_tx_step
  import dcmac_0_prbs_pkg::*;
#(
  parameter int COUNTER_MODE = 0
) (
  input  ctx_t seed,
  output bus_t dat
);

  if (COUNTER_MODE != 0) begin : g_cnt
    logic unused_lo;
    assign unused_lo = ^seed[7:0];
    for (genvar gi = 0; gi < BUS_BYTES; gi++) begin : g_byte
      assign dat[gi] = seed[15:8] + 8'(gi + 1);
    end
  end else begin : g_prbs
    ctx_t win [BUS_BYTES+1];
    assign win[0] = seed;
    for (genvar gi = 0; gi < BUS_BYTES; gi++) begin : g_byte
      assign win[gi+1] = prbs_byte_step(win[gi]);
      assign dat[gi]   = win[gi+1][15:8];
    end
  end

endmodule

// File: rtl/dcmac_0_prbs_tx_ts.sv
// Time-sliced PRBS/counter source: per-ID context store, 2-stage pipeline, same-ID forwarding.
// Optional corrupt-beat injection is enabled by defining DCMAC_PRBS_TX_ERR_INJ_EN.
module dcmac_0_prbs_tx_ts
  import dcmac_0_prbs_pkg::*;
#(
  parameter int          COUNTER_MODE = 0,
  parameter int          NUM_ID       = 6,
  parameter logic [15:0] INIT_SEED    = INIT_SEED_DEF,
  localparam int         ID_W         = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [ID_W-1:0]  i_id,
  input  logic [7:0]       i_num_byte,
  input  logic             i_restart,
  input  logic             i_inject_err,
  output logic             o_vld,
  output logic [ID_W-1:0]  o_id,
  output logic [7:0]       o_num_byte,
  output logic [1535:0]    o_dat
);

  localparam int   CTX_N    = 1 << ID_W;
  localparam ctx_t CTX_INIT = (COUNTER_MODE != 0) ? 16'h0000 : INIT_SEED;

  logic            s1_vld_q, s1_vld_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic [7:0]      s1_num_q, s1_num_d;
  ctx_t            s1_seed_q, s1_seed_d;

  ctx_t ctx_q [CTX_N];
  ctx_t ctx_d [CTX_N];
  ctx_t ctx_new;

  logic            o_vld_q, o_vld_d;
  logic [ID_W-1:0] o_id_q, o_id_d;
  logic [7:0]      o_num_q, o_num_d;
  bus_t            o_dat_q, o_dat_d;

  bus_t gen_bytes;
  bus_t masked;
  logic inj_flip;

  // Stage 1: capture request; the lookup takes the in-flight write-back when S1 holds the same ID.
  always_comb begin
    ctx_t lookup;
    s1_vld_d = i_req && (int'(i_id) < NUM_ID);
    s1_id_d  = i_id;
    s1_num_d = (i_num_byte > MAX_BYTES) ? MAX_BYTES : i_num_byte;
    lookup   = ctx_q[i_id];
    if (s1_vld_q && (s1_id_q == i_id)) begin
      lookup = ctx_new;
    end
    s1_seed_d = i_restart ? CTX_INIT : lookup;
  end

  dcmac_0_prbs_tx_step #(.COUNTER_MODE(COUNTER_MODE)) u_step (
    .seed (s1_seed_q),
    .dat  (gen_bytes)
  );

  // Write-back value: last two generated bytes, with the old newest byte filling in when only one was made.
  always_comb begin
    ctx_new = s1_seed_q;
    if (s1_num_q != 8'd0) begin
      ctx_new[15:8] = gen_bytes[s1_num_q - 8'd1];
      ctx_new[7:0]  = (s1_num_q >= 8'd2) ? gen_bytes[s1_num_q - 8'd2] : s1_seed_q[15:8];
      if (COUNTER_MODE != 0) begin
        ctx_new[7:0] = 8'h00;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CTX_N; i++) begin
      ctx_d[i] = ctx_q[i];
      if (s1_vld_q && (s1_id_q == ID_W'(i))) begin
        ctx_d[i] = ctx_new;
      end
    end
  end

  for (genvar gi = 0; gi < BUS_BYTES; gi++) begin : g_mask
    assign masked[gi] = (8'(gi) < s1_num_q) ? gen_bytes[gi] : 8'h00;
  end

`ifdef DCMAC_PRBS_TX_ERR_INJ_EN
  logic s1_inj_q, s1_inj_d;
  assign s1_inj_d = i_inject_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_inj_q <= 1'b0;
    end else begin
      s1_inj_q <= s1_inj_d;
    end
  end
  // Only the output is corrupted; the context keeps the clean bytes so the stream stays in sync.
  assign inj_flip = s1_inj_q && (s1_num_q >= 8'd3);
`else
  logic unused_inj;
  assign unused_inj = i_inject_err;
  assign inj_flip   = 1'b0;
`endif

  always_comb begin
    o_vld_d = s1_vld_q;
    o_id_d  = o_id_q;
    o_num_d = o_num_q;
    o_dat_d = o_dat_q;
    if (s1_vld_q) begin
      o_id_d        = s1_id_q;
      o_num_d       = s1_num_q;
      o_dat_d       = masked;
      o_dat_d[0][0] = masked[0][0] ^ inj_flip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_id_q   <= '0;
      s1_num_q  <= '0;
      s1_seed_q <= '0;
      o_vld_q   <= 1'b0;
      o_id_q    <= '0;
      o_num_q   <= '0;
      o_dat_q   <= '0;
      for (int i = 0; i < CTX_N; i++) begin
        ctx_q[i] <= CTX_INIT;
      end
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_id_q   <= s1_id_d;
      s1_num_q  <= s1_num_d;
      s1_seed_q <= s1_seed_d;
      o_vld_q   <= o_vld_d;
      o_id_q    <= o_id_d;
      o_num_q   <= o_num_d;
      o_dat_q   <= o_dat_d;
      for (int i = 0; i < CTX_N; i++) begin
        ctx_q[i] <= ctx_d[i];
      end
    end
  end

  assign o_vld      = o_vld_q;
  assign o_id       = o_id_q;
  assign o_num_byte = o_num_q;
  assign o_dat      = o_dat_q;

endmodule
